// File: rtl/ack_gen_queue_pkg.sv
// Flit types, checksum helper and ACK queue constants.
// types is shared with the router; ack_gen_queue_pkg is local to this block.
package types;

  typedef struct packed {
    logic [7:0] src_id;
    logic [7:0] dst_id;
    logic [7:0] flit_id;
    logic [7:0] flit_type;
  } header_t;

  typedef struct packed {
    header_t     header;
    logic [31:0] payload;
    logic [7:0]  checksum;
  } flit_t;

  localparam logic [7:0] FLIT_TYPE_DATA = 8'h01;
  localparam logic [7:0] FLIT_TYPE_ACK  = 8'h02;
  localparam logic [7:0] FLIT_TYPE_NACK = 8'h03;

  // Byte sum over header and payload; the checksum field is excluded.
  function automatic logic [7:0] calc_checksum(flit_t f);
    logic [63:0] b;
    logic [7:0]  s;
    b = {f.header, f.payload};
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s = s + b[i*8 +: 8];
    end
    return s;
  endfunction

endpackage

package ack_gen_queue_pkg;

  localparam int          NACK_CNT_W   = 16;
  localparam logic [15:0] NACK_CNT_MAX = 16'hFFFF;

  function automatic int rr_next(int g, int n);
    return (g + 1 >= n) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/ack_gen_queue_fifo.sv
// ACK flit FIFO: registered storage, head read from registers only.
// Pointers wrap naturally because DEPTH is a power of two.
module ack_flit_fifo
  import types::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  flit_t            data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  output flit_t            head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  flit_t            mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/calculate_checksum_comb.sv
// Combinational flit checksum.
// Shared by ACK build and the optional receive check.
module calculate_checksum_comb
  import types::*;
(
  input  flit_t      flit_i,
  output logic [7:0] checksum_o
);

  assign checksum_o = calc_checksum(flit_i);

endmodule

// File: rtl/ack_gen_queue.sv
// Multi-channel ACK generator: round-robin arbiter, ACK build, FIFO.
// Define ACK_GEN_NACK_EN to verify input checksums and emit NACKs.
module ack_gen_queue
  import types::*;
  import ack_gen_queue_pkg::*;
#(
  parameter  int NUM_CH = 2,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      in_valid,
  input  flit_t [NUM_CH-1:0]     in_flit,
  output logic [NUM_CH-1:0]      in_ready,
  output logic                   out_valid,
  output flit_t                  out_flit,
  input  logic                   out_ready,
  output logic [CNT_W-1:0]       count
`ifdef ACK_GEN_NACK_EN
  ,
  output logic [NACK_CNT_W-1:0]  nack_cnt
`endif
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0] gnt_idx;
  logic            gnt_vld;
  logic            fifo_full;
  logic            fifo_empty;
  logic            accept;
  int              cand;
  flit_t           sel;
  flit_t           ack_raw;
  flit_t           ack_flit;
  logic [7:0]      ack_cs;
  logic [7:0]      ack_type;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = (int'(rr_ptr_q) + i) % NUM_CH;
      if (!gnt_vld && in_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = CH_W'(cand);
      end
    end
  end

  // No full-bypass: a pop in the same cycle does not free a slot early.
  assign accept = gnt_vld && !fifo_full && !rst;

  always_comb begin
    in_ready = '0;
    if (accept) in_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = CH_W'(rr_next(int'(gnt_idx), NUM_CH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign sel = in_flit[gnt_idx];

`ifdef ACK_GEN_NACK_EN
  logic [7:0]            rx_cs;
  logic                  rx_bad;
  logic [NACK_CNT_W-1:0] nack_cnt_q, nack_cnt_d;

  calculate_checksum_comb u_rx_cs (
    .flit_i     (sel),
    .checksum_o (rx_cs)
  );

  assign rx_bad   = (rx_cs != sel.checksum);
  assign ack_type = rx_bad ? FLIT_TYPE_NACK : FLIT_TYPE_ACK;

  always_comb begin
    nack_cnt_d = nack_cnt_q;
    if (accept && rx_bad && nack_cnt_q != NACK_CNT_MAX)
      nack_cnt_d = nack_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) nack_cnt_q <= '0;
    else     nack_cnt_q <= nack_cnt_d;
  end

  assign nack_cnt = nack_cnt_q;
`else
  assign ack_type = FLIT_TYPE_ACK;
`endif

  always_comb begin
    ack_raw                  = sel;
    ack_raw.header.src_id    = sel.header.dst_id;
    ack_raw.header.dst_id    = sel.header.src_id;
    ack_raw.header.flit_type = ack_type;
  end

  calculate_checksum_comb u_ack_cs (
    .flit_i     (ack_raw),
    .checksum_o (ack_cs)
  );

  always_comb begin
    ack_flit          = ack_raw;
    ack_flit.checksum = ack_cs;
  end

  ack_flit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .data_i  (ack_flit),
    .pop_i   (out_ready),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count),
    .head_o  (out_flit)
  );

  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_ack_gen_queue.sv
// Scoreboard bench for ack_gen_queue (NUM_CH=2, DEPTH=4).
// Reference arbiter and ACK builder run alongside the DUT.
module tb_ack_gen_queue;
  import types::*;

  localparam int N = 2;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_valid;
  flit_t [N-1:0] in_flit;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  flit_t         out_flit;
  logic          out_ready;
  logic [2:0]    count;
`ifdef ACK_GEN_NACK_EN
  logic [15:0]   nack_cnt;
`endif

  ack_gen_queue #(
    .NUM_CH (N),
    .DEPTH  (D)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_flit   (in_flit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_flit  (out_flit),
    .out_ready (out_ready),
    .count     (count)
`ifdef ACK_GEN_NACK_EN
    ,
    .nack_cnt  (nack_cnt)
`endif
  );

  always #5 clk = ~clk;

  int     n_chk = 0;
  int     n_err = 0;
  flit_t  sbq[$];
  int     glog[$];
  flit_t  pend [N];
  logic [N-1:0] offer;
  logic   ordy;
  int     rr = 0;
  int     seq = 0;
  int     exp_nack = 0;

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_cs(flit_t f);
    logic [7:0] s;
    s = f.header.src_id + f.header.dst_id;
    s = s + f.header.flit_id + f.header.flit_type;
    s = s + f.payload[31:24] + f.payload[23:16];
    s = s + f.payload[15:8] + f.payload[7:0];
    return s;
  endfunction

  function automatic flit_t new_flit();
    flit_t f;
    f.header.src_id    = 8'($urandom);
    f.header.dst_id    = 8'($urandom);
    f.header.flit_id   = 8'(seq);
    f.header.flit_type = FLIT_TYPE_DATA;
    f.payload          = $urandom;
    f.checksum         = ref_cs(f);
    seq++;
    return f;
  endfunction

  function automatic flit_t mk_ack(flit_t f);
    flit_t a;
    a = f;
    a.header.src_id    = f.header.dst_id;
    a.header.dst_id    = f.header.src_id;
    a.header.flit_type = FLIT_TYPE_ACK;
`ifdef ACK_GEN_NACK_EN
    if (ref_cs(f) != f.checksum) begin
      a.header.flit_type = FLIT_TYPE_NACK;
      if (exp_nack < 65535) exp_nack++;
    end
`endif
    a.checksum = ref_cs(a);
    return a;
  endfunction

  // One clock: drive, compare against the model, advance the model.
  task automatic cycle();
    int g;
    int c;
    logic [N-1:0] er;
    logic push, pop;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = offer[i];
      in_flit[i]  = pend[i];
    end
    out_ready = ordy;
    #1;
    g = -1;
    for (int i = 0; i < N; i++) begin
      c = (rr + i) % N;
      if (g < 0 && offer[c]) g = c;
    end
    push = (g >= 0) && (sbq.size() < D);
    pop  = (sbq.size() != 0) && ordy;
    er = '0;
    if (push) er[g] = 1'b1;
    check("in_ready", in_ready, er);
    check("count", count, sbq.size());
    check("out_valid", out_valid, sbq.size() != 0);
    check("no_ovf", count <= 3'(D), 1'b1);
    if (sbq.size() != 0) check("out_flit", out_flit, sbq[0]);
`ifdef ACK_GEN_NACK_EN
    check("nack_cnt", nack_cnt, exp_nack);
`endif
    @(posedge clk);
    if (pop) void'(sbq.pop_front());
    if (push) begin
      sbq.push_back(mk_ack(pend[g]));
      glog.push_back(g);
      rr = (g + 1) % N;
      pend[g] = new_flit();
    end
    #1;
  endtask

  task automatic drain();
    offer = '0;
    ordy  = 1'b1;
    for (int i = 0; i < D + 2; i++) cycle();
  endtask

  initial begin
    int st;
    for (int i = 0; i < N; i++) pend[i] = new_flit();
    rst       = 1'b1;
    in_valid  = '1;
    for (int i = 0; i < N; i++) in_flit[i] = pend[i];
    out_ready = 1'b1;
    offer     = '0;
    ordy      = 1'b0;
    #3;
    check("rst_in_ready", in_ready, 2'b00);
    check("rst_valid", out_valid, 1'b0);
    check("rst_count", count, 3'd0);
    check("rst_flit", out_flit, '0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single ACK with fixed ids
    pend[0].header.src_id  = 8'd3;
    pend[0].header.dst_id  = 8'd7;
    pend[0].header.flit_id = 8'd5;
    pend[0].checksum       = ref_cs(pend[0]);
    offer = 2'b01;
    cycle();
    check("ack_valid", out_valid, 1'b1);
    check("ack_src", out_flit.header.src_id, 8'd7);
    check("ack_dst", out_flit.header.dst_id, 8'd3);
    check("ack_id", out_flit.header.flit_id, 8'd5);
    check("ack_type", out_flit.header.flit_type, FLIT_TYPE_ACK);
    check("ack_cs", out_flit.checksum, ref_cs(out_flit));
    check("ack_cnt", count, 3'd1);
    drain();

    // Fairness: both channels busy, sink always ready
    glog.delete();
    st    = rr;
    offer = 2'b11;
    ordy  = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    check("rr_len", glog.size(), 8);
    for (int i = 0; i < glog.size(); i++)
      check("rr_seq", glog[i], (st + i) % N);
    drain();

    // Full and backpressure
    offer = 2'b11;
    ordy  = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    check("full_cnt", count, 3'd4);
    check("full_rdy", in_ready, 2'b00);
    drain();

    // Push and pop together at count 2, across pointer wrap
    offer = 2'b01;
    ordy  = 1'b0;
    cycle();
    cycle();
    offer = 2'b11;
    ordy  = 1'b1;
    for (int i = 0; i < 12; i++) cycle();
    check("pp_cnt", count, 3'd2);

    // Mid-stream reset at count 3
    drain();
    offer = 2'b01;
    ordy  = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("pre_rst_cnt", count, 3'd3);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_count", count, 3'd0);
    check("arst_flit", out_flit, '0);
    sbq.delete();
    rr = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    glog.delete();
    offer = 2'b11;
    cycle();
    check("post_rst_gnt", glog.size() == 1 && glog[0] == 0, 1'b1);
    drain();

`ifdef ACK_GEN_NACK_EN
    pend[0].checksum = pend[0].checksum ^ 8'h01;
    offer = 2'b01;
    ordy  = 1'b0;
    cycle();
    check("nack_type", out_flit.header.flit_type, FLIT_TYPE_NACK);
    check("nack_one", nack_cnt, 16'd1);
    cycle();
    drain();
`endif

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      offer = N'($urandom);
      ordy  = 1'($urandom);
      cycle();
    end
    drain();
    check("end_empty", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
